// File: rtl/mem_scan_reader.sv
// Scans every word of a single-port sync RAM on a button press, showing each word on the
// LEDs for HOLD_CYCLES while accumulating an XOR signature and an all-ones sticky flag.
module mem_scan_reader #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 16,
    parameter int HOLD_CYCLES = 20_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              button,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] douta,
    output logic [DATA_W-1:0] led,
    output logic              busy,
    output logic              done,
    output logic              ones_seen,
    output logic [DATA_W-1:0] sig
);

    localparam int CNT_W = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_HOLD,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              btn_meta_q, btn_meta_d;
    logic              btn_sync_q, btn_sync_d;
    logic              btn_prev_q, btn_prev_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] led_q, led_d;
    logic [DATA_W-1:0] sig_q, sig_d;
    logic              ones_q, ones_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic              ena_q, ena_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              start;

    // Rising edge of the synchronized button; a held button yields a single pulse.
    assign start = btn_sync_q & ~btn_prev_q;

    always_comb begin
        state_d    = state_q;
        btn_meta_d = button;
        btn_sync_d = btn_meta_q;
        btn_prev_d = btn_sync_q;
        addr_d     = addr_q;
        led_d      = led_q;
        sig_d      = sig_q;
        ones_d     = ones_q;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_READ;
                    addr_d  = '0;
                    sig_d   = '0;
                    ones_d  = 1'b0;
                end
            end
            S_READ: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                led_d      = douta;
                sig_d      = sig_q ^ douta;
                ones_d     = ones_q | (&douta);
                hold_cnt_d = '0;
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    if (addr_q == ADDR_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_READ;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs are decoded from the next state so they line up with state_q.
        ena_d  = (state_d == S_READ);
        busy_d = (state_d == S_READ) || (state_d == S_LATCH) || (state_d == S_HOLD);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
            addr_q     <= '0;
            led_q      <= '0;
            sig_q      <= '0;
            ones_q     <= 1'b0;
            hold_cnt_q <= '0;
            ena_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            btn_prev_q <= btn_prev_d;
            addr_q     <= addr_d;
            led_q      <= led_d;
            sig_q      <= sig_d;
            ones_q     <= ones_d;
            hold_cnt_q <= hold_cnt_d;
            ena_q      <= ena_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ena       = ena_q;
    assign wea       = 1'b0;
    assign addr      = addr_q;
    assign led       = led_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ones_seen = ones_q;
    assign sig       = sig_q;

endmodule

// File: tb/tb_mem_scan_reader.sv
// Scoreboard bench for mem_scan_reader: stimulus pushes per-word and end-of-scan
// expectations from a RAM snapshot; a forked monitor pops and compares as the DUT responds.
module tb_mem_scan_reader;

    localparam int HC    = 4;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 1 << AW;
    localparam int PER   = HC + 2;
    localparam int SCAN  = DEPTH * PER;

    logic          clk = 1'b0;
    logic          rst;
    logic          button;
    logic          ena, wea, busy, done, ones_seen;
    logic [AW-1:0] addr;
    logic [DW-1:0] douta = '0;
    logic [DW-1:0] led, sig;

    always #5 clk = ~clk;

    mem_scan_reader #(.ADDR_W(AW), .DATA_W(DW), .HOLD_CYCLES(HC)) dut (
        .clk(clk), .rst(rst), .button(button), .ena(ena), .wea(wea), .addr(addr),
        .douta(douta), .led(led), .busy(busy), .done(done), .ones_seen(ones_seen), .sig(sig)
    );

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) if (ena) douta <= mem[addr];

    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; bit first; } word_t;
    typedef struct { logic [DW-1:0] sig; bit ones; logic [DW-1:0] led; } final_t;
    word_t  exp_w[$];
    final_t exp_f[$];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Reference: a scan visits every address in order; results are XOR / any-all-ones.
    task automatic push_scan();
        final_t f;
        word_t  w;
        f.sig = '0; f.ones = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            w.a = AW'(i); w.d = mem[i]; w.first = (i == 0);
            exp_w.push_back(w);
            f.sig  = f.sig ^ mem[i];
            f.ones = f.ones | (mem[i] == 16'hFFFF);
        end
        f.led = mem[DEPTH-1];
        exp_f.push_back(f);
    endtask

    int            cyc = 0, start_cyc = 0, last_ena = 0, led_due = 0;
    bit            rst_prev = 1'b0, done_prev = 1'b0, led_pend = 1'b0;
    logic [DW-1:0] led_exp;

    task automatic monitor();
        word_t  w;
        final_t f;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_prev) begin
                chk("rst_ena", ena, 0);   chk("rst_addr", addr, 0); chk("rst_led", led, 0);
                chk("rst_busy", busy, 0); chk("rst_done", done, 0);
                chk("rst_ones", ones_seen, 0); chk("rst_sig", sig, 0);
            end
            if (rst) begin
                exp_w.delete(); exp_f.delete(); led_pend = 1'b0;
            end else if (!rst_prev) begin
                chk("wea_zero", wea, 0);
                chk("busy_done_excl", busy & done, 0);
                if (ena) begin
                    if (exp_w.size() == 0) chk("ena_unexpected", ena, 0);
                    else begin
                        w = exp_w.pop_front();
                        chk("ena_addr", addr, w.a);
                        if (w.first) begin
                            chk("start_sig_clr", sig, 0);
                            chk("start_ones_clr", ones_seen, 0);
                            chk("start_done_clr", done, 0);
                            chk("start_busy", busy, 1);
                            start_cyc = cyc;
                        end else chk("ena_spacing", cyc - last_ena, PER);
                        last_ena = cyc; led_pend = 1'b1; led_due = cyc + 2; led_exp = w.d;
                    end
                end
                if (led_pend && cyc == led_due) begin
                    chk("led_word", led, led_exp);
                    led_pend = 1'b0;
                end
                if (done && !done_prev) begin
                    if (exp_f.size() == 0) chk("done_unexpected", done, 0);
                    else begin
                        f = exp_f.pop_front();
                        chk("done_sig", sig, f.sig);
                        chk("done_ones", ones_seen, f.ones);
                        chk("done_led", led, f.led);
                        chk("done_addr", addr, DEPTH - 1);
                        chk("done_latency", cyc - start_cyc, SCAN);
                    end
                end
            end
            rst_prev  = rst;
            done_prev = done;
        end
    endtask

    // Press for 'hold' cycles; if bw >= 0, press again while word bw is being shown.
    task automatic run_scan(input int hold, input int bw);
        push_scan();
        button = 1'b1; tick(hold); button = 1'b0;
        if (bw >= 0) begin
            tick(3 + PER * bw + int'($urandom_range(0, PER - 1)) - hold);
            button = 1'b1; tick(3); button = 1'b0;
        end
        for (int n = 0; n < SCAN + 50 && exp_f.size() != 0; n++) tick(1);
        if (exp_f.size() != 0) chk("scan_timeout", exp_f.size(), 0);
        tick(4);
    endtask

    initial begin
        rst = 1'b1; button = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i) * 16'h1111;
        fork monitor(); join_none
        tick(3); rst = 1'b0; tick(3);

        run_scan(3, -1);                      // full scan, all-ones word present
        run_scan(4, -1);                      // restart from DONE, same contents
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
        run_scan(3, -1);                      // no all-ones word
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i) * 16'h1111;
        run_scan(3, 5);                       // press ignored while busy
        run_scan(200, -1);                    // long level press: one start only
        run_scan(3, -1);

        // Reset in the middle of a scan discards it.
        push_scan();
        button = 1'b1; tick(3); button = 1'b0;
        tick(int'($urandom_range(10, 80)));
        rst = 1'b1; tick(3); rst = 1'b0; tick(3);
        run_scan(3, -1);

        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
            if ($urandom_range(0, 2) == 0) mem[$urandom_range(0, DEPTH - 1)] = 16'hFFFF;
            run_scan(int'($urandom_range(2, 8)),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : -1);
        end

        tick(5);
        chk("words_drained", exp_w.size(), 0);
        chk("finals_drained", exp_f.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
